// File: rtl/color_button_encoder.sv
// Simon game button front end: synchronise, debounce and encode one colour press.
// Emits a single color_valid pulse per accepted press and multi_err for chords.
module color_button_encoder #(
    parameter int unsigned DEBOUNCE_CYCLES = 800000,
    parameter bit          BTN_ACTIVE_LOW  = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic [3:0] btn,
    output logic [2:0] color,
    output logic       color_valid,
    output logic       multi_err,
    output logic       busy
);

    localparam int unsigned      CNT_W        = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST     = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [2:0]       COLOR_NULL   = 3'b100;
    localparam logic [3:0]       RELEASED_RAW = {4{BTN_ACTIVE_LOW}};

    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_DEBOUNCE = 2'd1;
    localparam logic [1:0] ST_PRESSED  = 2'd2;
    localparam logic [1:0] ST_RELEASE  = 2'd3;

    logic [3:0]       sync1_q, sync2_q;
    logic [3:0]       s;
    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       cand_q, cand_d;
    logic [2:0]       color_q, color_d;
    logic             valid_q, valid_d;
    logic             merr_q, merr_d;

    function automatic logic [2:0] encode(input logic [3:0] onehot);
        case (onehot)
            4'b0001: encode = 3'b000;
            4'b0010: encode = 3'b001;
            4'b0100: encode = 3'b010;
            4'b1000: encode = 3'b011;
            default: encode = COLOR_NULL;
        endcase
    endfunction

    // s is 1 for pressed regardless of board polarity
    assign s = BTN_ACTIVE_LOW ? ~sync2_q : sync2_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        cand_d  = cand_q;
        color_d = color_q;
        valid_d = 1'b0;
        merr_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (s != '0 && enable) begin
                    cand_d  = s;
                    cnt_d   = '0;
                    state_d = ST_DEBOUNCE;
                end
            end
            ST_DEBOUNCE: begin
                if (s != cand_q) begin
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                end else if (cnt_q == CNT_LAST) begin
                    cnt_d = '0;
                    if ($onehot(cand_q)) begin
                        color_d = encode(cand_q);
                        valid_d = 1'b1;
                        state_d = ST_PRESSED;
                    end else begin
                        merr_d  = 1'b1;
                        state_d = ST_RELEASE;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_PRESSED: begin
                if (s != cand_q) begin
                    color_d = COLOR_NULL;
                    cnt_d   = '0;
                    state_d = ST_RELEASE;
                end
            end
            ST_RELEASE: begin
                if (s != '0) begin
                    cnt_d = '0;
                end else if (cnt_q == CNT_LAST) begin
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                cnt_d   = '0;
                color_d = COLOR_NULL;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q <= RELEASED_RAW;
            sync2_q <= RELEASED_RAW;
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            cand_q  <= '0;
            color_q <= COLOR_NULL;
            valid_q <= 1'b0;
            merr_q  <= 1'b0;
        end else begin
            sync1_q <= btn;
            sync2_q <= sync1_q;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            cand_q  <= cand_d;
            color_q <= color_d;
            valid_q <= valid_d;
            merr_q  <= merr_d;
        end
    end

    assign color       = color_q;
    assign color_valid = valid_q;
    assign multi_err   = merr_q;
    assign busy        = (state_q != ST_IDLE);

endmodule

// File: tb/tb_color_button_encoder.sv
// Directed bench for color_button_encoder with a scoreboard of expected press outcomes.
module tb_color_button_encoder;

    logic       clk = 1'b0;
    logic       reset;
    logic       enable;
    logic [3:0] btn;
    logic [2:0] color;
    logic       color_valid;
    logic       multi_err;
    logic       busy;

    typedef struct packed {
        logic       merr;
        logic [2:0] col;
    } event_t;

    event_t exp_q[$];
    int     total_cnt  = 0;
    int     passed_cnt = 0;
    int     pulse_cnt  = 0;

    color_button_encoder #(
        .DEBOUNCE_CYCLES(4),
        .BTN_ACTIVE_LOW (1'b1)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .btn        (btn),
        .color      (color),
        .color_valid(color_valid),
        .multi_err  (multi_err),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        total_cnt++;
        assert (obs === exp) passed_cnt++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic expect_event(input logic merr, input logic [2:0] col);
        event_t e;
        e.merr = merr;
        e.col  = col;
        exp_q.push_back(e);
    endtask

    // Pop one scoreboard entry for every pulse the DUT produces
    always @(negedge clk) begin
        if (!reset && (color_valid || multi_err)) begin
            event_t e;
            pulse_cnt++;
            check("valid_merr_exclusive", {3'b0, color_valid & multi_err}, 4'h0);
            if (exp_q.size() == 0) begin
                check("unexpected_pulse", {color_valid, multi_err, 2'b0}, 4'h0);
            end else begin
                e = exp_q.pop_front();
                check("sb_multi_err", {3'b0, multi_err}, {3'b0, e.merr});
                check("sb_color", {1'b0, color}, {1'b0, (e.merr ? 3'b100 : e.col)});
            end
        end
    end

    initial begin
        int pulses_before;
        reset  = 1'b1;
        enable = 1'b0;
        btn    = 4'hF;
        tick(2);
        check("rst_color", {1'b0, color}, 4'h4);
        check("rst_valid", {3'b0, color_valid}, 4'h0);
        check("rst_merr", {3'b0, multi_err}, 4'h0);
        check("rst_busy", {3'b0, busy}, 4'h0);
        reset = 1'b0;
        tick(1);

        // GREEN press and release
        enable = 1'b1;
        btn    = 4'b1101;
        expect_event(1'b0, 3'b001);
        tick(6);
        check("g_valid_e6", {3'b0, color_valid}, 4'h0);
        check("g_color_e6", {1'b0, color}, 4'h4);
        check("g_busy_e6", {3'b0, busy}, 4'h1);
        tick(1);
        check("g_valid_e7", {3'b0, color_valid}, 4'h1);
        check("g_color_e7", {1'b0, color}, 4'h1);
        tick(1);
        check("g_valid_e8", {3'b0, color_valid}, 4'h0);
        check("g_color_hold", {1'b0, color}, 4'h1);
        tick(5);
        btn = 4'hF;
        tick(2);
        check("g_rel_e2", {1'b0, color}, 4'h1);
        tick(1);
        check("g_rel_e3", {1'b0, color}, 4'h4);
        check("g_rel_busy_e3", {3'b0, busy}, 4'h1);
        tick(4);
        check("g_rel_busy_e7", {3'b0, busy}, 4'h0);

        // Bouncing GREEN never settles
        pulses_before = pulse_cnt;
        for (int i = 0; i < 5; i++) begin
            btn = 4'b1101;
            tick(2);
            btn = 4'hF;
            tick(2);
        end
        tick(8);
        check("bounce_pulses", 4'(pulse_cnt - pulses_before), 4'h0);
        check("bounce_color", {1'b0, color}, 4'h4);
        check("bounce_busy", {3'b0, busy}, 4'h0);

        // RED+YELLOW chord
        btn = 4'b0110;
        expect_event(1'b1, 3'b100);
        tick(7);
        check("m_merr_e7", {3'b0, multi_err}, 4'h1);
        check("m_valid_e7", {3'b0, color_valid}, 4'h0);
        check("m_color_e7", {1'b0, color}, 4'h4);
        tick(1);
        check("m_merr_e8", {3'b0, multi_err}, 4'h0);
        btn = 4'hF;
        tick(10);
        check("m_busy_done", {3'b0, busy}, 4'h0);

        // BLUE held while disabled, then enabled
        pulses_before = pulse_cnt;
        enable = 1'b0;
        btn    = 4'b1011;
        tick(10);
        check("dis_busy", {3'b0, busy}, 4'h0);
        check("dis_pulses", 4'(pulse_cnt - pulses_before), 4'h0);
        enable = 1'b1;
        expect_event(1'b0, 3'b010);
        tick(4);
        check("en_valid_f4", {3'b0, color_valid}, 4'h0);
        check("en_busy_f4", {3'b0, busy}, 4'h1);
        tick(1);
        check("en_valid_f5", {3'b0, color_valid}, 4'h1);
        check("en_color_f5", {1'b0, color}, 4'h2);
        btn    = 4'hF;
        enable = 1'b0;
        tick(10);
        check("en_rel_busy", {3'b0, busy}, 4'h0);
        check("en_rel_color", {1'b0, color}, 4'h4);

        // Reset mid-DEBOUNCE and mid-PRESSED
        enable = 1'b1;
        btn    = 4'b1110;
        tick(5);
        pulses_before = pulse_cnt;
        reset = 1'b1;
        tick(1);
        check("rd_color", {1'b0, color}, 4'h4);
        check("rd_valid", {3'b0, color_valid}, 4'h0);
        check("rd_busy", {3'b0, busy}, 4'h0);
        check("rd_pulses", 4'(pulse_cnt - pulses_before), 4'h0);
        reset = 1'b0;
        expect_event(1'b0, 3'b000);
        tick(7);
        check("r_valid", {3'b0, color_valid}, 4'h1);
        check("r_color", {1'b0, color}, 4'h0);
        tick(2);
        reset = 1'b1;
        tick(1);
        check("rp_color", {1'b0, color}, 4'h4);
        check("rp_valid", {3'b0, color_valid}, 4'h0);
        check("rp_busy", {3'b0, busy}, 4'h0);
        reset = 1'b0;
        btn   = 4'hF;
        tick(10);
        check("rp_color_after", {1'b0, color}, 4'h4);
        check("rp_busy_after", {3'b0, busy}, 4'h0);
        check("sb_drained", 4'(exp_q.size()), 4'h0);

        $display("%0d/%0d checks passed", passed_cnt, total_cnt);
        $finish;
    end

endmodule
